// File: rtl/mem_pkg.sv
// Purpose: shared encodings for the data-memory path (access size, responder FSM state).
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: mem_size_t, dmem_state_t, MEM_SIZE_* encodings reused by the core's
//           control decoder, and the misaligned() helper.
package mem_pkg;

  // Access size as carried on req_size; 2'b11 is deliberately left unnamed in
  // the enum because it is an illegal request, not a size.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } mem_size_t;

  localparam logic [1:0] MEM_SIZE_B   = SZ_B;
  localparam logic [1:0] MEM_SIZE_H   = SZ_H;
  localparam logic [1:0] MEM_SIZE_W   = SZ_W;
  localparam logic [1:0] MEM_SIZE_BAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Halves need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic m;
    m = 1'b0;
    case (size)
      MEM_SIZE_H: m = addr_lo[0];
      MEM_SIZE_W: m = |addr_lo;
      default:    m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Purpose: byte-lane steering between right-justified core data and the 32-bit array word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: size/addr_lo/is_unsigned select the lanes; wdata -> be + wdata_rep for stores;
//        rword -> rdata_ext (shifted down, sign/zero-extended) for loads.
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rword[7:0];
    case (addr_lo)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  // Store data is replicated into every lane so the byte enables alone decide
  // which lanes land; no shifter is needed on the write path.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = 32'h0;
    case (size)
      MEM_SIZE_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      MEM_SIZE_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = is_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      MEM_SIZE_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rword;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: load/store target for the RV32I core with configurable wait states and error responses.
// Latency: handshake cycle N -> resp_valid in cycle N+1+WAIT_STATES; one access per WAIT_STATES+2 cycles.
// Backpressure: response held stable until resp_ready; req_ready is low outside IDLE.
// Ports: clk, reset (async, active-high); req_valid/req_ready with req_we, req_size,
//        req_unsigned, req_addr, req_wdata; resp_valid/resp_ready with resp_rdata, resp_err.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,          // power of two, >= 2
  parameter int          WAIT_STATES = 2,            // 0..15
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000 // aligned to DEPTH_WORDS*4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t state;
  logic [3:0]  cnt;

  logic        q_we;
  logic [1:0]  q_size;
  logic        q_unsigned;
  logic [31:0] q_addr;
  logic [31:0] q_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  // Access operands: with zero wait states the access happens on the accept
  // edge itself, before the capture registers hold the request, so the live
  // inputs are used while in IDLE.
  logic        a_we;
  logic [1:0]  a_size;
  logic        a_unsigned;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;

  logic        accept;
  logic        do_access;
  logic [31:0] offset;
  logic [31:0] word_off;
  logic [IDX_W-1:0] idx;
  logic        out_of_range;
  logic        acc_err;
  logic        mem_we;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  always_comb begin
    if (state == IDLE) begin
      a_we       = req_we;
      a_size     = req_size;
      a_unsigned = req_unsigned;
      a_addr     = req_addr;
      a_wdata    = req_wdata;
    end else begin
      a_we       = q_we;
      a_size     = q_size;
      a_unsigned = q_unsigned;
      a_addr     = q_addr;
      a_wdata    = q_wdata;
    end
  end

  // Access fires exactly on the edge that enters RESP. Gated by reset so a
  // reset arriving mid-WAIT cannot leak a write into the array.
  always_comb begin
    do_access = 1'b0;
    if (!reset) begin
      if (state == IDLE && accept && WAIT_STATES == 0) do_access = 1'b1;
      if (state == WAIT && cnt == 4'd0)                do_access = 1'b1;
    end
  end

  // Offset is modulo 2^32, so addresses below BASE_ADDR wrap to huge offsets
  // and fall out of range naturally.
  assign offset       = a_addr - BASE_ADDR;
  assign word_off     = offset >> 2;
  assign idx          = word_off[IDX_W-1:0];
  assign out_of_range = (word_off >= 32'(DEPTH_WORDS));
  assign acc_err      = (a_size == MEM_SIZE_BAD) || misaligned(a_size, a_addr[1:0]) || out_of_range;
  assign mem_we       = do_access && a_we && !acc_err;

  dmem_lane_align u_lane_align (
    .size        (a_size),
    .addr_lo     (a_addr[1:0]),
    .is_unsigned (a_unsigned),
    .wdata       (a_wdata),
    .rword       (mem[idx]),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      q_we       <= 1'b0;
      q_size     <= 2'b00;
      q_unsigned <= 1'b0;
      q_addr     <= 32'h0;
      q_wdata    <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            q_we       <= req_we;
            q_size     <= req_size;
            q_unsigned <= req_unsigned;
            q_addr     <= req_addr;
            q_wdata    <= req_wdata;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (do_access) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || a_we) ? 32'h0 : rdata_ext;
      end
    end
  end

  // Array deliberately has no reset: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        resp_ready_a = 1'b0, resp_ready_b = 1'b0;

  logic        req_ready_a, resp_valid_a, resp_err_a;
  logic [31:0] resp_rdata_a;
  logic        req_ready_b, resp_valid_b, resp_err_b;
  logic [31:0] resp_rdata_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready_a), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0000_1000)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? req_ready_b : req_ready_a;
  endfunction
  function automatic logic rv(input bit sel);
    return sel ? resp_valid_b : resp_valid_a;
  endfunction
  function automatic logic [31:0] rd(input bit sel);
    return sel ? resp_rdata_b : resp_rdata_a;
  endfunction
  function automatic logic re(input bit sel);
    return sel ? resp_err_b : resp_err_a;
  endfunction

  // One full transaction. lat counts clock edges from the start of the
  // handshake cycle to the first edge after which resp_valid is high.
  task automatic xfer(input string tag, input bit sel, input bit we, input logic [1:0] size,
                      input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input int hold, output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!rdy(sel) && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    // Garbage on the request bus after acceptance must not matter.
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD; req_size = 2'b11; req_we = ~we;
    lat = 1;
    while (!rv(sel) && lat < 40) begin @(posedge clk); #1; lat++; end
    if (lat >= 40) chk({tag, "_timeout"}, 32'(rv(sel)), 32'h1);
    rdata = rd(sel);
    err   = re(sel);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(rv(sel)), 32'h1);
      chk({tag, "_hold_rdata"}, rd(sel), rdata);
      chk({tag, "_hold_err"}, 32'(re(sel)), 32'(err));
      chk({tag, "_hold_reqrdy"}, 32'(rdy(sel)), 32'h0);
    end
    if (sel) resp_ready_b = 1'b1; else resp_ready_a = 1'b1;
    @(posedge clk); #1;
    resp_ready_a = 1'b0; resp_ready_b = 1'b0;
    chk({tag, "_drop"}, 32'(rv(sel)), 32'h0);
  endtask

  task automatic txn(input string tag, input bit sel, input bit we, input logic [1:0] size,
                     input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] r;
    logic        e;
    int          lat;
    xfer(tag, sel, we, size, uns, addr, wdata, 0, r, e, lat);
    chk({tag, "_rdata"}, r, exp_rd);
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
    chk({tag, "_lat"}, 32'(lat), sel ? 32'd1 : 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat, acc, rsp;

    // Reset values
    #3;
    chk("rst_req_ready", 32'(req_ready_a), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid_a), 32'h0);
    chk("rst_rdata", resp_rdata_a, 32'h0);
    chk("rst_err", 32'(resp_err_a), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("idle_req_ready", 32'(req_ready_a), 32'h1);
    @(posedge clk); #1;

    // Word store/load and lane behaviour, WAIT_STATES=2
    txn("sw10",     0, 1, MEM_SIZE_W,   0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    txn("lw10",     0, 0, MEM_SIZE_W,   0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    txn("sb12",     0, 1, MEM_SIZE_B,   0, 32'h12,  32'hFFFFFF55, 32'h0,        0);
    txn("lw10_b",   0, 0, MEM_SIZE_W,   0, 32'h10,  32'h0,        32'hDE55BEEF, 0);
    txn("lb13",     0, 0, MEM_SIZE_B,   0, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
    txn("lbu13",    0, 0, MEM_SIZE_B,   1, 32'h13,  32'h0,        32'h000000DE, 0);
    txn("lb12",     0, 0, MEM_SIZE_B,   0, 32'h12,  32'h0,        32'h00000055, 0);
    txn("lh10",     0, 0, MEM_SIZE_H,   0, 32'h10,  32'h0,        32'hFFFFBEEF, 0);
    txn("lhu10",    0, 0, MEM_SIZE_H,   1, 32'h10,  32'h0,        32'h0000BEEF, 0);
    txn("lh12",     0, 0, MEM_SIZE_H,   0, 32'h12,  32'h0,        32'hFFFFDE55, 0);
    txn("sh12",     0, 1, MEM_SIZE_H,   0, 32'h12,  32'h00001234, 32'h0,        0);
    txn("lw10_c",   0, 0, MEM_SIZE_W,   0, 32'h10,  32'h0,        32'h1234BEEF, 0);

    // Errors
    txn("lw11",     0, 0, MEM_SIZE_W,   0, 32'h11,  32'h0,        32'h0,        1);
    txn("sh13",     0, 1, MEM_SIZE_H,   0, 32'h13,  32'h0000AAAA, 32'h0,        1);
    txn("lw10_d",   0, 0, MEM_SIZE_W,   0, 32'h10,  32'h0,        32'h1234BEEF, 0);
    txn("lw_oob",   0, 0, MEM_SIZE_W,   0, 32'h400, 32'h0,        32'h0,        1);
    txn("sz11",     0, 0, MEM_SIZE_BAD, 0, 32'h10,  32'h0,        32'h0,        1);
    txn("lw_last",  0, 1, MEM_SIZE_W,   0, 32'h3FC, 32'h600DCAFE, 32'h0,        0);
    txn("lw_last_r",0, 0, MEM_SIZE_W,   0, 32'h3FC, 32'h0,        32'h600DCAFE, 0);

    // Backpressure: response held five cycles
    xfer("bp", 0, 0, MEM_SIZE_W, 0, 32'h10, 32'h0, 5, r, e, lat);
    chk("bp_rdata", r, 32'h1234BEEF);
    chk("bp_lat", 32'(lat), 32'd3);

    // Reset while in WAIT abandons the store
    txn("sw20",     0, 1, MEM_SIZE_W,   0, 32'h20,  32'hCAFEF00D, 32'h0,        0);
    req_we = 1'b1; req_size = MEM_SIZE_W; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678; req_valid_a = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rw_rst_valid", 32'(resp_valid_a), 32'h0);
    chk("rw_rst_reqrdy", 32'(req_ready_a), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rw_post_valid", 32'(resp_valid_a), 32'h0);
    chk("rw_post_reqrdy", 32'(req_ready_a), 32'h1);
    @(posedge clk); #1;
    txn("lw20",     0, 0, MEM_SIZE_W,   0, 32'h20,  32'h0,        32'hCAFEF00D, 0);

    // WAIT_STATES=0 instance, BASE_ADDR=0x1000
    txn("b_sw",     1, 1, MEM_SIZE_W,   0, 32'h1008, 32'h11223344, 32'h0,        0);
    txn("b_lw",     1, 0, MEM_SIZE_W,   0, 32'h1008, 32'h0,        32'h11223344, 0);
    txn("b_lbu",    1, 0, MEM_SIZE_B,   1, 32'h100B, 32'h0,        32'h00000011, 0);
    txn("b_below",  1, 0, MEM_SIZE_W,   0, 32'h0FFC, 32'h0,        32'h0,        1);
    txn("b_oob",    1, 0, MEM_SIZE_W,   0, 32'h1400, 32'h0,        32'h0,        1);
    txn("b_swlast", 1, 1, MEM_SIZE_W,   0, 32'h13FC, 32'hA5A50001, 32'h0,        0);
    txn("b_lwlast", 1, 0, MEM_SIZE_W,   0, 32'h13FC, 32'h0,        32'hA5A50001, 0);

    // Back-to-back loads with resp_ready held: one per two cycles
    req_we = 1'b0; req_size = MEM_SIZE_W; req_unsigned = 1'b0; req_addr = 32'h1008;
    req_valid_b = 1'b1; resp_ready_b = 1'b1;
    acc = 0; rsp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready_b) acc++;
      if (resp_valid_b) begin
        rsp++;
        chk("b2b_rdata", resp_rdata_b, 32'h11223344);
      end
    end
    req_valid_b = 1'b0;
    @(posedge clk); #1;
    resp_ready_b = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd5);
    chk("b2b_resps", 32'(rsp), 32'd5);
    chk("b2b_idle", 32'(resp_valid_b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I core. It is the target end of the core's load/store interface: it accepts one request per handshake, inserts a configurable number of wait states, and performs byte/half/word accesses on an internal word-organised array. It returns read data, sign- or zero-extended, through a response handshake. It replaces the zero-latency memory model so the core and its future stall logic can be exercised against realistic latency and error responses.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words in the array; power of two.
- `WAIT_STATES`, 2: extra cycles between request acceptance and response; 0–15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal.
- `req_unsigned` in 1: zero-extend loads (lbu/lhu); ignored for word and for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: response present.
- `resp_ready` in 1: requester accepts response.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: access faulted.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. When `req_valid`&&`req_ready`, capture we/size/unsigned/addr/wdata. Go to WAIT if `WAIT_STATES`>0, otherwise go to RESP. Load counter = `WAIT_STATES`-1.
- WAIT: `req_ready`=0. Decrement the counter. When the counter is 0, perform the access and go to RESP.
- RESP: `resp_valid`=1. Outputs are stable until `resp_ready`. On `resp_valid`&&`resp_ready`, go to IDLE. There is no same-cycle accept of a new request; `req_ready` is 0 in RESP.
- The access is performed exactly once, on the edge that enters RESP:
  - Error if the size is 11.
  - Error if the access is misaligned: half with addr[0]≠0, word with addr[1:0]≠0.
  - Error if (addr−`BASE_ADDR`)>>2 ≥ `DEPTH_WORDS`.
  - On error there is no array write, `resp_rdata`=0 and `resp_err`=1.
- Store: write only the addressed lanes. Byte lane = addr[1:0]; half lanes = addr[1]. Other bytes are unchanged.
- Load: select the lane(s) and shift down. Sign-extend from bit 7 or 15 unless `req_unsigned`. Word loads are returned unchanged.
- Address offsets are computed modulo 2^32; addresses below `BASE_ADDR` wrap and fail the range check.
- The array is not initialised by reset. Contents are preserved across reset.

## Timing
- Reset values: `req_ready`=0 while `reset` is asserted, then 1 in IDLE; `resp_valid`=0, `resp_rdata`=0, `resp_err`=0; state = IDLE; counter = 0.
- Latency: request accepted on edge N → `resp_valid` high from edge N+1+`WAIT_STATES` onward.
- Throughput: one access per `WAIT_STATES`+2 cycles when `resp_ready` is held at 1.
- Reset mid-operation, while in WAIT: the pending access is abandoned and no write occurs.
- Reset mid-operation, while in RESP: the write is already committed and the response is dropped.
- `resp_ready` held low: the response is held indefinitely with no timeout.
- Inputs are sampled only in IDLE. Changes on the `req_*` inputs after acceptance are ignored.

## Structure
- Shared package `mem_pkg` holds:
  - the `mem_size_t` enum (SZ_B, SZ_H, SZ_W);
  - the `dmem_state_t` enum (IDLE, WAIT, RESP);
  - the size encodings, which the core's control decoder reuses.
- Sub-module `dmem_lane_align` (combinational) provides store byte-enable/data replication and load extract/extend from size, addr[1:0] and unsigned.
- The array is inferred RAM with byte-enable write.

## Test plan
- Word store/load, WAIT_STATES=2: store 0xDEADBEEF to 0x10, then load word 0x10 → rdata 0xDEADBEEF, err 0; resp_valid exactly 3 cycles after each accept.
- Lanes: after 0xDEADBEEF at 0x10, store byte 0x55 to 0x12 → load word gives 0xDE55BEEF. Then:
  - lb 0x13 → 0xFFFFFFDE
  - lbu 0x13 → 0x000000DE
  - lh 0x10 → 0xFFFFBEEF
  - lhu 0x10 → 0x0000BEEF
- Errors:
  - lw 0x11 → err 1, rdata 0.
  - sh 0x13 → err 1, and a subsequent load word 0x10 returns the value written before it, unchanged.
  - lw at BASE+DEPTH_WORDS*4 → err 1.
  - size 11 → err 1.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid, rdata and err stay stable; req_ready=0 throughout; completes one cycle after resp_ready=1.
- Reset in WAIT: store 0x12345678 to 0x20 and assert reset one cycle after accept → after release, lw 0x20 returns the prior contents and resp_valid=0 immediately after reset.
- WAIT_STATES=0 build: accept on edge N → resp_valid at N+1; back-to-back loads achieve one per 2 cycles.
